// File: rtl/iram_fetch_ctrl.sv
// Instruction-RAM fetch controller: host program loading plus sequential
// fetch with consumer back-pressure and a halt opcode.
module iram_fetch_ctrl #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ack,
   input  logic              run,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              ir_valid,
   input  logic              ir_taken,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_HOLD, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              ir_valid_q, ir_valid_d;
   logic              ret_halt_q, ret_halt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         ir_valid_q <= 1'b0;
         ret_halt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ir_valid_q <= ir_valid_d;
         ret_halt_q <= ret_halt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ir_valid_d = ir_valid_q;
      ret_halt_d = ret_halt_q;
      case (state_q)
         S_IDLE: begin
            if (pc_load) pc_d = pc_in;
            if (load_req) begin
               state_d    = S_LOAD;
               ret_halt_d = 1'b0;
            end else if (run) begin
               state_d = S_FETCH;
            end
         end
         S_LOAD:  state_d = ret_halt_q ? S_HALT : S_IDLE;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            instr_d    = ram_rdata;
            pc_d       = pc_q + 1'b1;
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (ir_taken) begin
               ir_valid_d = 1'b0;
               if (instr_q[15:12] == HALT_OP) state_d = S_HALT;
               else if (run)                  state_d = S_FETCH;
               else                           state_d = S_IDLE;
            end
         end
         S_HALT: begin
            if (pc_load) pc_d = pc_in;
            // a pc_load alongside the load leaves HALT, so the load returns to IDLE
            if (load_req) begin
               state_d    = S_LOAD;
               ret_halt_d = !pc_load;
            end else if (pc_load) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = pc_q;
      ram_wdata = '0;
      load_ack  = 1'b0;
      case (state_q)
         S_LOAD: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = load_addr;
            ram_wdata = load_data;
            load_ack  = 1'b1;
         end
         S_FETCH: ram_en = 1'b1;
         default: ;
      endcase
   end

   assign halted    = (state_q == S_HALT);
   assign ir_valid  = ir_valid_q;
   assign instr_out = instr_q;
   assign pc_out    = pc_q;

endmodule

// File: doc/iram_fetch_ctrl.md
IRAM_FETCH_CTRL -- requirements
Module: iram_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter HALT_OP, default 4'hF, opcode (instr[15:12]) that halts sequencing.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 load_req  in  1  host requests one program-word write.
REQ-008 load_addr  in  ADDR_W  host write address.
REQ-009 load_data  in  DATA_W  host write data.
REQ-010 load_ack  out  1  one-cycle pulse; write performed this cycle.
REQ-011 run  in  1  level; enables fetching.
REQ-012 pc_load  in  1  request to set the program counter.
REQ-013 pc_in  in  ADDR_W  new program-counter value.
REQ-014 ir_valid  out  1  instr_out holds a fetched word.
REQ-015 ir_taken  in  1  consumer accepts instr_out.
REQ-016 instr_out  out  DATA_W  fetched instruction.
REQ-017 pc_out  out  ADDR_W  current program counter.
REQ-018 halted  out  1  HALT state indicator.
REQ-019 ram_en, ram_we  out  1 each  RAM enable and write strobe.
REQ-020 ram_addr  out  ADDR_W  RAM address; ram_wdata  out  DATA_W  RAM write data.
REQ-021 ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read-enabled edge.

Function
REQ-022 SHALL implement the FSM states IDLE, LOAD, FETCH, WAIT, HOLD and HALT.
REQ-023 IDLE: if load_req, SHALL go to LOAD (load has priority); else if run, SHALL go to FETCH; else SHALL stay in IDLE.
REQ-024 LOAD: SHALL drive ram_en=1, ram_we=1, ram_addr=load_addr, ram_wdata=load_data and load_ack=1 for exactly one cycle, then return to the originating state (IDLE or HALT).
REQ-025 FETCH: SHALL drive ram_en=1, ram_we=0, ram_addr=pc, then go to WAIT.
REQ-026 WAIT: SHALL register instr_out<=ram_rdata, set pc<=pc+1 (modulo 2^ADDR_W, so 255 wraps to 0), set ir_valid<=1, then go to HOLD.
REQ-027 HOLD: ir_valid and instr_out SHALL stay stable until ir_taken=1.
REQ-028 On ir_taken in HOLD, ir_valid SHALL clear next cycle and the next state SHALL be HALT if instr_out[15:12]==HALT_OP, else FETCH if run=1, else IDLE.
REQ-029 Fetch throughput SHALL be 3 cycles per instruction (FETCH, WAIT, HOLD) when ir_taken is held high.
REQ-030 In FETCH, WAIT and HOLD, load_req SHALL be ignored (no ack); the host holds load_req until load_ack.
REQ-031 HALT: halted=1; run SHALL be ignored; load_req SHALL be granted (LOAD, then return to HALT).
REQ-032 pc_load SHALL be honoured only in IDLE or HALT: pc<=pc_in next cycle; from HALT the next state SHALL be IDLE unless load_req is also set.
REQ-033 pc_load SHALL be ignored in other states.
REQ-034 pc_load together with load_req in IDLE or HALT: the pc update SHALL take effect and LOAD SHALL be entered, returning to IDLE.
REQ-035 Outside LOAD and FETCH, ram_en and ram_we SHALL be 0.
REQ-036 Outside LOAD, ram_we SHALL be 0.
REQ-037 ram_addr SHALL equal pc when not in LOAD.
REQ-038 Deassertion of run during WAIT or HOLD SHALL NOT abort the current fetch; it takes effect at the HOLD exit.

Reset
REQ-039 reset=1 SHALL asynchronously force state=IDLE, pc=0, instr_out=0, ir_valid=0, load_ack=0, halted=0, ram_en=0 and ram_we=0.
REQ-040 Reset asserted mid-LOAD or mid-FETCH SHALL abort the operation with no completed ack or valid.
REQ-041 Fetching SHALL resume only after reset deassertion and run=1.

Verification
REQ-042 Load test: load words 0x1234@0, 0x2345@1 and 0xF000@2, then run=1 with ir_taken=1 -> instr_out sequence 0x1234, 0x2345, 0xF000; halted=1 after the third; pc_out=3.
REQ-043 Backpressure test: hold ir_taken=0 for 5 cycles in HOLD -> ir_valid stays 1, instr_out stable, pc unchanged, no RAM access.
REQ-044 Wrap test: pc_load=1, pc_in=0xFF in IDLE, RAM[0xFF]=0x0001, run -> after fetch, pc_out=0x00.
REQ-045 Arbitration test: load_req and run both high in IDLE -> LOAD first (load_ack one cycle), FETCH on the next IDLE.
REQ-046 Arbitration test: load_req raised during HOLD -> no ack until IDLE or HALT.
REQ-047 Reset test: assert reset in WAIT -> all outputs 0 immediately (asynchronously); after release with run=1, fetch restarts at address 0.
